// File: rtl/axis_packet_fifo.sv
// AXI-Stream FIFO with first-word fall-through output. PKT_LEN = 0 gives plain
// streaming; PKT_LEN > 0 releases data only in whole packets of that length, with TLAST.
module axis_packet_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int PKT_LEN    = 0
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    input_V_V_TVALID,
  output logic                    input_V_V_TREADY,
  input  logic [DATA_WIDTH-1:0]   input_V_V_TDATA,
  output logic                    output_V_V_TVALID,
  input  logic                    output_V_V_TREADY,
  output logic [DATA_WIDTH-1:0]   output_V_V_TDATA,
  output logic                    output_V_V_TLAST,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int   AW       = $clog2(DEPTH);
  localparam int   CW       = AW + 1;
  localparam logic PKT_MODE = (PKT_LEN != 0);

  typedef enum logic {IDLE, DRAIN} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count, count_next;
  logic [CW-1:0]         remaining, remaining_next;
  state_t                state, state_next;
  logic                  ready_q;
  logic                  wr_fire, rd_fire;

  assign wr_fire = input_V_V_TVALID & ready_q;
  assign rd_fire = output_V_V_TVALID & output_V_V_TREADY;

  always_comb begin
    case ({wr_fire, rd_fire})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    case (state)
      IDLE: begin
        if (PKT_MODE && count >= CW'(PKT_LEN)) begin
          state_next     = DRAIN;
          remaining_next = CW'(PKT_LEN);
        end
      end
      DRAIN: begin
        if (rd_fire) begin
          remaining_next = remaining - CW'(1);
          if (remaining == CW'(1)) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      remaining <= '0;
      state     <= IDLE;
      ready_q   <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
      if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
      count     <= count_next;
      remaining <= remaining_next;
      state     <= state_next;
      // Registered so TREADY never depends on TVALID and stays low during reset.
      ready_q   <= (count_next < CW'(DEPTH));
    end
  end

  // NOTE: storage has no reset; stale contents are never visible since TVALID gates them.
  always_ff @(posedge aclk) begin
    if (wr_fire) mem[wr_ptr] <= input_V_V_TDATA;
  end

  assign input_V_V_TREADY  = ready_q;
  assign output_V_V_TVALID = PKT_MODE ? (state == DRAIN) : (count != '0);
  assign output_V_V_TLAST  = PKT_MODE && (state == DRAIN) && (remaining == CW'(1));
  assign output_V_V_TDATA  = mem[rd_ptr];
  assign level             = count;

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Directed bench: a stream-mode and a packet-mode (PKT_LEN=4) instance side by side,
// a vector table for single-cycle behaviour and hand sequences for the long cases.
module tb_axis_packet_fifo;

  localparam int DW = 32;
  localparam int DEPTH = 16;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;

  logic          s_in_valid = 0, s_in_ready, s_out_valid, s_out_ready = 0, s_last;
  logic [DW-1:0] s_in_data = '0, s_out_data;
  logic [4:0]    s_level;

  logic          p_in_valid = 0, p_in_ready, p_out_valid, p_out_ready = 0, p_last;
  logic [DW-1:0] p_in_data = '0, p_out_data;
  logic [4:0]    p_level;

  always #5 aclk = ~aclk;

  axis_packet_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PKT_LEN(0)) u_stream (
    .aclk(aclk), .aresetn(aresetn),
    .input_V_V_TVALID(s_in_valid), .input_V_V_TREADY(s_in_ready), .input_V_V_TDATA(s_in_data),
    .output_V_V_TVALID(s_out_valid), .output_V_V_TREADY(s_out_ready),
    .output_V_V_TDATA(s_out_data), .output_V_V_TLAST(s_last), .level(s_level));

  axis_packet_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PKT_LEN(4)) u_pkt (
    .aclk(aclk), .aresetn(aresetn),
    .input_V_V_TVALID(p_in_valid), .input_V_V_TREADY(p_in_ready), .input_V_V_TDATA(p_in_data),
    .output_V_V_TVALID(p_out_valid), .output_V_V_TREADY(p_out_ready),
    .output_V_V_TDATA(p_out_data), .output_V_V_TLAST(p_last), .level(p_level));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Drives the selected instance's inputs; the other instance sits idle.
  task automatic drive(input bit pkt, input bit v, input logic [31:0] d, input bit r);
    s_in_valid = !pkt && v;  s_in_data = d;  s_out_ready = !pkt && r;
    p_in_valid = pkt && v;   p_in_data = d;  p_out_ready = pkt && r;
  endtask

  typedef struct {
    bit          pkt;
    bit          in_valid;
    logic [31:0] in_data;
    bit          out_ready;
    bit          exp_in_ready;
    bit          exp_out_valid;
    logic [31:0] exp_data;
    bit          exp_last;
    int          exp_level;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int rd_i, wr_i, pkts, cyc;

    // Stream: 0x11,0x22,0x33 back-to-back with the sink always ready.
    vecs.push_back('{0, 1, 32'h11, 1, 1, 0, 32'h0,  0, 0});
    vecs.push_back('{0, 1, 32'h22, 1, 1, 1, 32'h11, 0, 1});
    vecs.push_back('{0, 1, 32'h33, 1, 1, 1, 32'h22, 0, 1});
    vecs.push_back('{0, 0, 32'h0,  1, 1, 1, 32'h33, 0, 1});
    vecs.push_back('{0, 0, 32'h0,  1, 1, 0, 32'h0,  0, 0});
    // Packet: nothing visible until four words are held; one bubble after TLAST.
    vecs.push_back('{1, 1, 32'hA0, 1, 1, 0, 32'h0,  0, 0});
    vecs.push_back('{1, 1, 32'hA1, 1, 1, 0, 32'h0,  0, 1});
    vecs.push_back('{1, 1, 32'hA2, 1, 1, 0, 32'h0,  0, 2});
    vecs.push_back('{1, 1, 32'hA3, 1, 1, 0, 32'h0,  0, 3});
    vecs.push_back('{1, 0, 32'h0,  1, 1, 0, 32'h0,  0, 4});
    vecs.push_back('{1, 0, 32'h0,  1, 1, 1, 32'hA0, 0, 4});
    vecs.push_back('{1, 0, 32'h0,  1, 1, 1, 32'hA1, 0, 3});
    vecs.push_back('{1, 0, 32'h0,  1, 1, 1, 32'hA2, 0, 2});
    vecs.push_back('{1, 0, 32'h0,  1, 1, 1, 32'hA3, 1, 1});
    vecs.push_back('{1, 0, 32'h0,  1, 1, 0, 32'h0,  0, 0});

    // Reset state
    drive(0, 0, 0, 0);
    #12;
    check("rst_s_ready", s_in_ready, 0);
    check("rst_s_valid", s_out_valid, 0);
    check("rst_s_level", s_level, 0);
    check("rst_p_ready", p_in_ready, 0);
    check("rst_p_valid", p_out_valid, 0);
    check("rst_p_last",  p_last, 0);
    @(negedge aclk);
    aresetn = 1'b1;

    foreach (vecs[i]) begin
      @(negedge aclk);
      drive(vecs[i].pkt, vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
      #1;
      if (vecs[i].pkt) begin
        check($sformatf("v%0d_ready", i), p_in_ready, vecs[i].exp_in_ready);
        check($sformatf("v%0d_valid", i), p_out_valid, vecs[i].exp_out_valid);
        if (vecs[i].exp_out_valid) check($sformatf("v%0d_data", i), p_out_data, vecs[i].exp_data);
        check($sformatf("v%0d_last", i), p_last, vecs[i].exp_last);
        check($sformatf("v%0d_level", i), p_level, vecs[i].exp_level);
      end else begin
        check($sformatf("v%0d_ready", i), s_in_ready, vecs[i].exp_in_ready);
        check($sformatf("v%0d_valid", i), s_out_valid, vecs[i].exp_out_valid);
        if (vecs[i].exp_out_valid) check($sformatf("v%0d_data", i), s_out_data, vecs[i].exp_data);
        check($sformatf("v%0d_last", i), s_last, vecs[i].exp_last);
        check($sformatf("v%0d_level", i), s_level, vecs[i].exp_level);
      end
    end

    // Stream: fill to full with sink stalled, hold the 17th word, free one slot.
    for (int i = 0; i < 16; i++) begin
      @(negedge aclk);
      drive(0, 1, 32'h100 + i, 0);
      #1 check("full_fill_ready", s_in_ready, 1);
    end
    @(negedge aclk);
    drive(0, 1, 32'h110, 0);
    #1;
    check("full_ready", s_in_ready, 0);
    check("full_level", s_level, 16);
    check("full_head",  s_out_data, 32'h100);
    @(negedge aclk);
    drive(0, 1, 32'h110, 1);
    #1 check("full_hold_ready", s_in_ready, 0);
    @(negedge aclk);
    drive(0, 1, 32'h110, 0);
    #1;
    check("full_freed_ready", s_in_ready, 1);
    check("full_freed_level", s_level, 15);
    @(negedge aclk);
    drive(0, 0, 0, 0);
    #1 check("full_refill_level", s_level, 16);
    for (int i = 0; i < 16; i++) begin
      @(negedge aclk);
      drive(0, 0, 0, 1);
      #1;
      check("full_drain_valid", s_out_valid, 1);
      check("full_drain_data", s_out_data, 32'h101 + i);
    end
    @(negedge aclk);
    drive(0, 0, 0, 0);
    #1 check("full_empty_valid", s_out_valid, 0);

    // Stream: simultaneous read and write at level 5.
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      drive(0, 1, 32'h200 + i, 0);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      drive(0, 1, 32'h205 + k, 1);
      #1;
      check("rw_level", s_level, 5);
      check("rw_data", s_out_data, 32'h200 + k);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      drive(0, 0, 0, 1);
      #1 check("rw_drain_data", s_out_data, 32'h203 + i);
    end
    @(negedge aclk);
    drive(0, 0, 0, 0);
    #1 check("rw_empty_level", s_level, 0);

    // Packet: 40 words streamed through with the sink always ready.
    rd_i = 0; wr_i = 0; pkts = 0; cyc = 0;
    while (rd_i < 40 && cyc < 400) begin
      @(negedge aclk);
      drive(1, wr_i < 40, 32'h300 + wr_i, 1);
      #1;
      if (p_out_valid) begin
        check("cont_data", p_out_data, 32'h300 + rd_i);
        check("cont_last", p_last, (rd_i % 4) == 3);
        if (p_last) pkts++;
        rd_i++;
      end
      if (p_in_valid && p_in_ready) wr_i++;
      cyc++;
    end
    check("cont_words", rd_i, 40);
    check("cont_packets", pkts, 10);
    @(negedge aclk);
    drive(1, 0, 0, 0);
    #1 check("cont_empty_level", p_level, 0);

    // Packet: reset after two of four words drained, then a clean packet.
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      drive(1, 1, 32'h400 + i, 0);
    end
    @(negedge aclk);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge aclk);
      drive(1, 0, 0, 1);
      #1 check("mid_data", p_out_data, 32'h400 + i);
    end
    @(negedge aclk);
    drive(1, 0, 0, 0);
    aresetn = 1'b0;
    #1;
    check("mid_rst_valid", p_out_valid, 0);
    check("mid_rst_level", p_level, 0);
    check("mid_rst_last",  p_last, 0);
    check("mid_rst_ready", p_in_ready, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      drive(1, 1, 32'h500 + i, 0);
      #1 check("post_ready", p_in_ready, 1);
    end
    @(negedge aclk);
    drive(1, 0, 0, 1);
    #1 check("post_idle_valid", p_out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      drive(1, 0, 0, 1);
      #1;
      check("post_valid", p_out_valid, 1);
      check("post_data", p_out_data, 32'h500 + i);
      check("post_last", p_last, i == 3);
    end
    @(negedge aclk);
    drive(1, 0, 0, 0);
    #1;
    check("post_bubble_valid", p_out_valid, 0);
    check("post_level", p_level, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
